gate_access_scheduler: RTL and testbench
========================================

# gate_access_scheduler

Sequencing controller for a single shared barrier gate serving an entry lane and an exit lane of a capacity-limited parking area. Arbitrates level-sensitive entry/exit requests round-robin, issues one-cycle open/close commands to the gate actuator, holds the gate open until a vehicle passes or a dwell timeout expires, and tracks occupancy so entries are refused when full and exits when empty.

## Interface

- CAPACITY, default 8: maximum vehicles inside; must be 1..2^CNT_W-1
- CNT_W, default 4: occupancy counter width
- OPEN_CYCLES, default 16: maximum OPEN dwell in clk cycles; must be ≥1
- TIMER_W, default 8: dwell timer width; OPEN_CYCLES ≤ 2^TIMER_W
- One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- entry_req  in  1  level, vehicle waiting at entry lane
- exit_req  in  1  level, vehicle waiting at exit lane
- vehicle_passed  in  1  single-cycle pulse from loop sensor under gate
- gate_open  out  1  one-cycle open command to actuator
- gate_close  out  1  one-cycle close command to actuator
- busy  out  1  high whenever state ≠ IDLE
- dir  out  1  direction of current/last grant (0 entry, 1 exit)
- occupancy  out  CNT_W  vehicles currently inside
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0

## Operation

- States: IDLE, GRANT, OPEN, CLOSE. Moore outputs: gate_open=1 only in GRANT, gate_close=1 only in CLOSE.
- Eligibility in IDLE: entry eligible = entry_req & ~full; exit eligible = exit_req & ~empty.
- IDLE: no eligible request → stay. One eligible → GRANT, dir set to it. Both eligible → grant opposite of last_dir (round-robin).
- last_dir register resets to 1, so first tie goes to entry; updated on every grant.
- GRANT → OPEN unconditionally; dwell timer cleared.
- OPEN: vehicle_passed=1 → CLOSE, occupancy +1 (dir=0) or −1 (dir=1) at that edge. Else timer increments; when timer == OPEN_CYCLES−1 with no pass → CLOSE, occupancy unchanged.
- Pass and timeout in same cycle: pass wins, counted.
- CLOSE → IDLE unconditionally.
- vehicle_passed outside OPEN is ignored (no count change).
- Requests sampled only in IDLE; changes in other states have no effect.
- Occupancy never wraps: eligibility rules guarantee no increment at CAPACITY, no decrement at 0.
- full/empty are combinational from occupancy.

## Timing

- Reset values: state IDLE, gate_open 0, gate_close 0, busy 0, dir 0, occupancy 0, full 0 (CAPACITY≥1), empty 1, timer 0, last_dir 1.
- Request eligible in IDLE at cycle N → gate_open high in cycle N+1 → OPEN from N+2.
- Pass pulse in OPEN cycle M → gate_close high in M+1, occupancy updated visible in M+1, IDLE in M+2.
- Timeout: OPEN lasts exactly OPEN_CYCLES cycles, then one CLOSE cycle.
- Minimum grant-to-grant spacing: 4 cycles (GRANT, OPEN, CLOSE, IDLE).
- Reset mid-operation: all registers return to reset values immediately; occupancy is lost (re-initialised to 0) and no close command is issued.

## Structure

- Package gate_sched_pkg: state encoding (IDLE=2'b00, GRANT=2'b01, OPEN=2'b10, CLOSE=2'b11) and direction constants DIR_ENTRY=1'b0, DIR_EXIT=1'b1.
- Sub-module gate_occupancy_counter (params CAPACITY, CNT_W; inputs inc, dec; outputs occupancy, full, empty); scheduler FSM, arbiter and dwell timer stay in the top.

## Test plan

- CAPACITY=2, OPEN_CYCLES=4: entry_req held, vehicle_passed pulsed 2nd OPEN cycle → gate_open 1 cycle, gate_close 1 cycle, occupancy 0→1, dir=0.
- Both requests held from reset with occupancy 1 → grants alternate entry, exit, entry, ...; first grant entry; occupancy stays within 0..2.
- Entry only, no pass → OPEN exactly 4 cycles, gate_close, occupancy unchanged, back to IDLE.
- Occupancy 2 (full): entry_req alone → no grant, busy stays 0; exit_req added → exit granted, pass → occupancy 1, full 0.
- From reset, exit_req alone (empty=1) → never granted; vehicle_passed pulses in IDLE → occupancy stays 0.
- Reset asserted in OPEN with occupancy 1 → same cycle: state IDLE, occupancy 0, gate_open/gate_close 0, last_dir 1.

Source files
------------

// File: rtl/gate_access_scheduler_pkg.sv
// gate_sched_pkg: state encoding and lane direction constants for the gate scheduler.
package gate_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        OPEN  = 2'b10,
        CLOSE = 2'b11
    } state_t;
    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;
endpackage

// File: rtl/gate_access_scheduler_if.sv
// gate_access_scheduler_if: lane requests, gate commands and occupancy status.
interface gate_access_scheduler_if #(parameter int CNT_W = 4);
    logic             entry_req;
    logic             exit_req;
    logic             vehicle_passed;
    logic             gate_open;
    logic             gate_close;
    logic             busy;
    logic             dir;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    modport master (
        output entry_req, exit_req, vehicle_passed,
        input  gate_open, gate_close, busy, dir, occupancy, full, empty
    );
    modport slave (
        input  entry_req, exit_req, vehicle_passed,
        output gate_open, gate_close, busy, dir, occupancy, full, empty
    );
endinterface

// File: rtl/gate_access_scheduler_occupancy_counter.sv
// gate_occupancy_counter: saturating vehicle count with full/empty flags.
module gate_occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);
    assign full  = occupancy == CNT_W'(CAPACITY);
    assign empty = occupancy == '0;
    // Guards are redundant with the arbiter's eligibility rules but keep the count from wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) occupancy <= '0;
        else occupancy <= (inc && !full) ? occupancy + 1'b1 :
                          (dec && !empty) ? occupancy - 1'b1 : occupancy;
    end
endmodule

// File: rtl/gate_access_scheduler.sv
// gate_access_scheduler: round-robin entry/exit arbiter and gate sequencer with dwell timeout.
module gate_access_scheduler
    import gate_sched_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16,
    parameter int TIMER_W     = 8
) (
    input logic clk,
    input logic reset,
    gate_access_scheduler_if.slave bus
);
    state_t             state, state_n;
    logic [TIMER_W-1:0] timer;
    logic               dir, last_dir, grant_dir;
    logic               ent_ok, ext_ok, pass, timeout;
    assign ent_ok    = bus.entry_req & ~bus.full;
    assign ext_ok    = bus.exit_req & ~bus.empty;
    assign grant_dir = (ent_ok && ext_ok) ? ~last_dir : (ext_ok ? DIR_EXIT : DIR_ENTRY);
    assign pass      = (state == OPEN) && bus.vehicle_passed;
    assign timeout   = timer == TIMER_W'(OPEN_CYCLES - 1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (ent_ok || ext_ok) ? GRANT : IDLE;
            GRANT:   state_n = OPEN;
            OPEN:    state_n = (pass || timeout) ? CLOSE : OPEN;
            CLOSE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            dir      <= DIR_ENTRY;
            last_dir <= DIR_EXIT;
        end else begin
            state <= state_n;
            timer <= (state == OPEN) ? timer + 1'b1 : '0;
            if (state == IDLE && (ent_ok || ext_ok)) begin
                dir      <= grant_dir;
                last_dir <= grant_dir;
            end
        end
    end
    assign bus.gate_open  = state == GRANT;
    assign bus.gate_close = state == CLOSE;
    assign bus.busy       = state != IDLE;
    assign bus.dir        = dir;
    gate_occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_occ (
        .clk       (clk),
        .reset     (reset),
        .inc       (pass && dir == DIR_ENTRY),
        .dec       (pass && dir == DIR_EXIT),
        .occupancy (bus.occupancy),
        .full      (bus.full),
        .empty     (bus.empty)
    );
endmodule

// File: tb/tb_gate_access_scheduler.sv
// tb_gate_access_scheduler: scenario tasks checked against a timestamp-based transaction model.
module tb_gate_access_scheduler;
    localparam int CAP = 2;
    localparam int OC  = 4;
    localparam int CW  = 4;
    logic clk = 0;
    logic reset = 0;
    int tests = 0;
    int fails = 0;
    gate_access_scheduler_if #(.CNT_W(CW)) bus ();
    gate_access_scheduler #(.CAPACITY(CAP), .CNT_W(CW), .OPEN_CYCLES(OC), .TIMER_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    // Model: a transaction is a grant at age 0, open ages 1..close_at-1, close at age close_at.
    int mocc, age, close_at;
    bit mlast, mdir, in_txn;

    function automatic logic [9:0] exp_vec();
        return {in_txn && age == 0, in_txn && age == close_at, in_txn, mdir,
                4'(mocc), mocc == CAP, mocc == 0};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {bus.gate_open, bus.gate_close, bus.busy, bus.dir, bus.occupancy, bus.full, bus.empty};
    endfunction

    task automatic model_reset();
        mocc = 0; mlast = 1; mdir = 0; in_txn = 0; age = 0; close_at = 0;
    endtask

    task automatic model_next(input bit e, input bit x, input bit p);
        bit ent, ext;
        if (!in_txn) begin
            ent = e && mocc < CAP;
            ext = x && mocc > 0;
            if (ent || ext) begin
                mdir = (ent && ext) ? ~mlast : ext;
                mlast = mdir;
                in_txn = 1; age = 0; close_at = OC + 1;
            end
        end else begin
            if (p && age >= 1 && age < close_at) begin
                close_at = age + 1;
                mocc += mdir ? -1 : 1;
            end
            if (age == close_at) in_txn = 0;
            else age++;
        end
    endtask

    task automatic step(input bit e, input bit x, input bit p);
        bus.entry_req = e; bus.exit_req = x; bus.vehicle_passed = p;
        model_next(e, x, p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.entry_req = 0; bus.exit_req = 0; bus.vehicle_passed = 0;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs_vec() !== 10'b0000_0000_01) begin
            fails++; $display("FAIL reset_state got=%b exp=%b", obs_vec(), 10'b0000000001);
        end
    endtask

    task automatic test_entry_pass();
        bit tab [6][3] = '{'{1,0,0}, '{0,0,0}, '{0,0,0}, '{0,0,1}, '{0,0,0}, '{0,0,0}};
        int opens = 0, closes = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tab[i][0], tab[i][1], tab[i][2]);
            opens += int'(bus.gate_open); closes += int'(bus.gate_close);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL entry_pass cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (opens != 1 || closes != 1 || bus.occupancy !== 4'd1 || bus.dir !== 1'b0) begin
            fails++; $display("FAIL entry_pass_summary got open=%0d close=%0d occ=%0d dir=%b exp 1 1 1 0",
                              opens, closes, bus.occupancy, bus.dir);
        end
    endtask

    task automatic test_timeout();
        int busy_cyc = 0;
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            busy_cyc += int'(bus.busy);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            step(0, 0, 0);
        end
        tests++;
        if (busy_cyc != OC + 2 || bus.occupancy !== 4'd0) begin
            fails++; $display("FAIL timeout_len got busy=%0d occ=%0d exp busy=%0d occ=0",
                              busy_cyc, bus.occupancy, OC + 2);
        end
    endtask

    task automatic test_alternate();
        int n = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, 1, in_txn && age == 1);
            tests++;
            if (obs_vec() !== exp_vec() || bus.occupancy > CAP) begin
                fails++; $display("FAIL alternate cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (bus.gate_open) begin
                tests++;
                if (bus.dir !== 1'(n % 2)) begin
                    fails++; $display("FAIL alternate_dir grant=%0d got=%b exp=%b", n, bus.dir, 1'(n % 2));
                end
                n++;
            end
        end
        tests++;
        if (n < 8) begin
            fails++; $display("FAIL alternate_grants got=%0d exp>=8", n);
        end
    endtask

    task automatic test_full();
        bit granted = 0;
        do_reset();
        for (int i = 0; i < 14; i++) step(!in_txn, 0, in_txn && age == 1);
        tests++;
        if (bus.occupancy !== 4'd2 || bus.full !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL full_fill got occ=%0d full=%b busy=%b exp 2 1 0",
                              bus.occupancy, bus.full, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            tests++;
            if (bus.busy !== 1'b0 || obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL full_refuse cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 5 && !granted; i++) begin
            step(1, 1, 0);
            granted = bus.gate_open;
        end
        tests++;
        if (!granted || bus.dir !== 1'b1) begin
            fails++; $display("FAIL full_exit_grant got granted=%b dir=%b exp 1 1", granted, bus.dir);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, age == 1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL full_exit cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (bus.occupancy !== 4'd1 || bus.full !== 1'b0) begin
            fails++; $display("FAIL full_exit_occ got occ=%0d full=%b exp 1 0", bus.occupancy, bus.full);
        end
    endtask

    task automatic test_empty();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1'($urandom_range(0, 1)));
            tests++;
            if (bus.busy !== 1'b0 || bus.occupancy !== 4'd0 || bus.empty !== 1'b1) begin
                fails++; $display("FAIL empty_refuse cyc=%0d got busy=%b occ=%0d empty=%b exp 0 0 1",
                                  i, bus.busy, bus.occupancy, bus.empty);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) step(!in_txn && mocc == 0, 0, in_txn && age == 1);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        tests++;
        if (bus.busy !== 1'b1 || bus.occupancy !== 4'd1 || bus.gate_open !== 1'b0 || bus.gate_close !== 1'b0) begin
            fails++; $display("FAIL reset_mid_pre got=%b exp busy=1 occ=1 in OPEN", obs_vec());
        end
        reset = 1;
        #1;
        tests++;
        if (obs_vec() !== 10'b0000000001) begin
            fails++; $display("FAIL reset_mid got=%b exp=%b", obs_vec(), 10'b0000000001);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        step(1, 1, 0);
        tests++;
        if (bus.gate_open !== 1'b1 || bus.dir !== 1'b0) begin
            fails++; $display("FAIL reset_mid_regrant got open=%b dir=%b exp 1 0", bus.gate_open, bus.dir);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry_pass();
        test_timeout();
        test_alternate();
        test_full();
        test_empty();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
